// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard detection and forwarding control for a 5-stage in-order pipeline.
//   The block keeps its own copy of the control fields of the EX, MEM and WB
//   stages. From that copy it derives the load-use stall, the branch flush and
//   the EX operand forward selects. All state changes on the falling clock
//   edge, which is the same edge the pipeline registers use.
//
//   Optional feature: define HAZARD_CTRL_PERF_EN to build saturating
//   performance counters. When the macro is not defined, no counter registers
//   exist and the perf_* outputs are tied to zero.
//
// Ports
//   clk, rst                      clock (falling-edge state), async active-high reset
//   id_valid                      ID stage holds a real instruction
//   id_rs_addr, id_rt_addr        ID source register addresses
//   id_uses_rs, id_uses_rt        ID instruction reads rs / rt
//   id_dst_addr                   ID destination register (after reg_dst mux)
//   id_reg_write, id_mem_to_reg   ID control bits
//   ex_branch_taken               branch resolved taken in EX this cycle
//   stall_f, stall_d              hold the PC and the IF/ID register
//   flush_d, flush_e              invalidate IF/ID and ID/EX at the next edge
//   fwd_a, fwd_b                  EX operand source: 00 regfile, 01 WB, 10 MEM
//   ex_valid, mem_valid, wb_valid per-stage valid bits
//   perf_retired/stalls/flushes   performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  ex_branch_taken,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [CNT_W-1:0]      perf_retired,
    output logic [CNT_W-1:0]      perf_stalls,
    output logic [CNT_W-1:0]      perf_flushes
);

    // EX stage copy
    logic                  e_valid_q, e_valid_d;
    logic                  e_rw_q;
    logic                  e_m2r_q;
    logic [REG_ADDR_W-1:0] e_dst_q;
    logic [REG_ADDR_W-1:0] e_rs_q;
    logic [REG_ADDR_W-1:0] e_rt_q;
    // MEM stage copy
    logic                  m_valid_q;
    logic                  m_rw_q;
    logic                  m_m2r_q;
    logic [REG_ADDR_W-1:0] m_dst_q;
    // WB stage copy
    logic                  w_valid_q;
    logic                  w_rw_q;
    logic                  w_m2r_q;
    logic [REG_ADDR_W-1:0] w_dst_q;

    logic load_use;

    // An address can carry a dependency unless it is the hardwired zero register.
    function automatic logic addr_live(input logic [REG_ADDR_W-1:0] a);
        return (ZERO_REG_EN == 0) || (a != '0);
    endfunction

    // MEM is the younger producer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mv,
        input logic                  mrw,
        input logic [REG_ADDR_W-1:0] mdst,
        input logic                  wv,
        input logic                  wrw,
        input logic [REG_ADDR_W-1:0] wdst
    );
        if (mv && mrw && (mdst == src) && addr_live(mdst)) begin
            return 2'b10;
        end else if (wv && wrw && (wdst == src) && addr_live(wdst)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        load_use = 1'b0;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;

        load_use = id_valid && e_valid_q && e_rw_q && e_m2r_q && addr_live(e_dst_q) &&
                   ((id_uses_rs && (id_rs_addr == e_dst_q)) ||
                    (id_uses_rt && (id_rt_addr == e_dst_q)));

        // Outputs are forced low while reset is held, including the flush that
        // would otherwise follow ex_branch_taken straight through. A taken
        // branch discards the stalled instruction, so it cancels the stall.
        if (!rst) begin
            flush_d = ex_branch_taken;
            flush_e = ex_branch_taken;
            stall_f = load_use && !ex_branch_taken;
            stall_d = load_use && !ex_branch_taken;
            if (e_valid_q) begin
                fwd_a = fwd_sel(e_rs_q, m_valid_q, m_rw_q, m_dst_q, w_valid_q, w_rw_q, w_dst_q);
                fwd_b = fwd_sel(e_rt_q, m_valid_q, m_rw_q, m_dst_q, w_valid_q, w_rw_q, w_dst_q);
            end
        end

        // A stall or a flush turns the instruction entering EX into a bubble.
        e_valid_d = id_valid && !stall_d && !flush_e;
    end

    assign ex_valid  = e_valid_q;
    assign mem_valid = m_valid_q;
    assign wb_valid  = w_valid_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_rw_q    <= 1'b0;
            e_m2r_q   <= 1'b0;
            e_dst_q   <= '0;
            e_rs_q    <= '0;
            e_rt_q    <= '0;
            m_valid_q <= 1'b0;
            m_rw_q    <= 1'b0;
            m_m2r_q   <= 1'b0;
            m_dst_q   <= '0;
            w_valid_q <= 1'b0;
            w_rw_q    <= 1'b0;
            w_m2r_q   <= 1'b0;
            w_dst_q   <= '0;
        end else begin
            w_valid_q <= m_valid_q;
            w_rw_q    <= m_rw_q;
            w_m2r_q   <= m_m2r_q;
            w_dst_q   <= m_dst_q;
            m_valid_q <= e_valid_q;
            m_rw_q    <= e_rw_q;
            m_m2r_q   <= e_m2r_q;
            m_dst_q   <= e_dst_q;
            e_valid_q <= e_valid_d;
            e_rw_q    <= id_reg_write;
            e_m2r_q   <= id_mem_to_reg;
            e_dst_q   <= id_dst_addr;
            e_rs_q    <= id_rs_addr;
            e_rt_q    <= id_rt_addr;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stalls_q;
    logic [CNT_W-1:0] flushes_q;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            retired_q <= sat_inc(retired_q, w_valid_q);
            stalls_q  <= sat_inc(stalls_q, stall_d);
            flushes_q <= sat_inc(flushes_q, ex_branch_taken);
        end
    end

    assign perf_retired = retired_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`else
    // The MEM/WB load flags only feed the counter build; fold them into a
    // signal that is otherwise unused so the default build carries no dangling state.
    logic perf_unused;
    assign perf_unused  = m_m2r_q ^ w_m2r_q;
    assign perf_retired = {CNT_W{perf_unused & 1'b0}};
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

`ifdef HAZARD_CTRL_PERF_EN
    // The MEM/WB load flags are carried for completeness of the stage copies.
    logic perf_unused;
    assign perf_unused = m_m2r_q ^ w_m2r_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b1;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs_addr = '0;
    logic [AW-1:0] id_rt_addr = '0;
    logic          id_uses_rs = 1'b0;
    logic          id_uses_rt = 1'b0;
    logic [AW-1:0] id_dst_addr = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_to_reg = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic [1:0]    fwd_a, fwd_b;
    logic          ex_valid, mem_valid, wb_valid;
    logic [CW-1:0] perf_retired, perf_stalls, perf_flushes;

    hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW), .ZERO_REG_EN(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .ex_branch_taken(ex_branch_taken),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .perf_retired(perf_retired), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Instructions in flight after ID: index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic          v;
        logic          rw;
        logic          m2r;
        logic [AW-1:0] dst;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } instr_t;

    instr_t inflight[3] = '{default: '0};
    int m_ret = 0;
    int m_stl = 0;
    int m_fl  = 0;

    function automatic logic writes_reg(input instr_t i, input logic [AW-1:0] r);
        return i.v && i.rw && (i.dst != 0) && (i.dst == r);
    endfunction

    function automatic logic exp_stall();
        instr_t e;
        e = inflight[0];
        if (rst || ex_branch_taken || !id_valid || !e.m2r) return 1'b0;
        return (id_uses_rs && writes_reg(e, id_rs_addr)) ||
               (id_uses_rt && writes_reg(e, id_rt_addr));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
        if (rst || !inflight[0].v) return 2'b00;
        if (writes_reg(inflight[1], src)) return 2'b10;
        if (writes_reg(inflight[2], src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int exp_perf(input int m);
`ifdef HAZARD_CTRL_PERF_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    function automatic int sat(input int c, input logic en);
        return (en && c < CMAX) ? c + 1 : c;
    endfunction

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            inflight[0] <= '0;
            inflight[1] <= '0;
            inflight[2] <= '0;
            m_ret <= 0;
            m_stl <= 0;
            m_fl  <= 0;
        end else begin
            m_ret <= sat(m_ret, inflight[2].v);
            m_stl <= sat(m_stl, exp_stall());
            m_fl  <= sat(m_fl, ex_branch_taken);
            inflight[2] <= inflight[1];
            inflight[1] <= inflight[0];
            inflight[0] <= '{v: id_valid && !exp_stall() && !ex_branch_taken,
                             rw: id_reg_write, m2r: id_mem_to_reg,
                             dst: id_dst_addr, rs: id_rs_addr, rt: id_rt_addr};
        end
    end

    // Every rising edge sits mid-cycle, away from the falling state edge.
    always @(posedge clk) begin
        chk("stall_f",   {31'b0, stall_f},   {31'b0, exp_stall()});
        chk("stall_d",   {31'b0, stall_d},   {31'b0, exp_stall()});
        chk("flush_d",   {31'b0, flush_d},   {31'b0, !rst && ex_branch_taken});
        chk("flush_e",   {31'b0, flush_e},   {31'b0, !rst && ex_branch_taken});
        chk("fwd_a",     {30'b0, fwd_a},     {30'b0, exp_fwd(inflight[0].rs)});
        chk("fwd_b",     {30'b0, fwd_b},     {30'b0, exp_fwd(inflight[0].rt)});
        chk("ex_valid",  {31'b0, ex_valid},  {31'b0, inflight[0].v});
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, inflight[1].v});
        chk("wb_valid",  {31'b0, wb_valid},  {31'b0, inflight[2].v});
        chk("perf_retired", 32'(perf_retired), exp_perf(m_ret));
        chk("perf_stalls",  32'(perf_stalls),  exp_perf(m_stl));
        chk("perf_flushes", 32'(perf_flushes), exp_perf(m_fl));
    end

    // ---------------- stimulus ----------------
    // Inputs change just after the falling edge; the task returns just after
    // the following rising edge so the caller can inspect that cycle.
    task automatic step(input logic r, input logic v, input logic [AW-1:0] dst,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic m2r, input logic br);
        @(negedge clk);
        #1;
        rst = r; id_valid = v; id_dst_addr = dst; id_rs_addr = rs; id_rt_addr = rt;
        id_uses_rs = urs; id_uses_rt = urt; id_reg_write = rw; id_mem_to_reg = m2r;
        ex_branch_taken = br;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic r);
        step(r, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [AW-1:0] d, input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic br);
        step(1'b0, 1'b1, d, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, br);
    endtask

    task automatic lw(input logic [AW-1:0] d, input logic [AW-1:0] base);
        step(1'b0, 1'b1, d, base, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // Reset state, with a branch request that must not leak through.
        step(1'b1, 1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_flush_d", {31'b0, flush_d}, 32'd0);
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_fwd_a", {30'b0, fwd_a}, 32'd0);
        nop(1'b1);

        // First instruction after release reaches WB three falling edges later.
        step(1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nop(1'b0);
        nop(1'b0);
        chk("first_mem", {31'b0, mem_valid}, 32'd1);
        chk("first_wb_early", {31'b0, wb_valid}, 32'd0);
        nop(1'b0);
        chk("first_wb", {31'b0, wb_valid}, 32'd1);

        // ALU to ALU: add $3 ; sub rs=$3
        alu(5'd3, 5'd1, 5'd2, 1'b0);
        alu(5'd4, 5'd3, 5'd6, 1'b0);
        chk("alu_nostall", {31'b0, stall_d}, 32'd0);
        nop(1'b0);
        chk("alu_fwd_a", {30'b0, fwd_a}, 32'd2);
        chk("alu_fwd_b", {30'b0, fwd_b}, 32'd0);

        // Two apart: add $3 ; nop ; or rt=$3
        alu(5'd3, 5'd1, 5'd2, 1'b0);
        nop(1'b0);
        alu(5'd7, 5'd1, 5'd3, 1'b0);
        nop(1'b0);
        chk("two_apart_fwd_b", {30'b0, fwd_b}, 32'd1);

        // Same with $0: never forwarded.
        alu(5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b0);
        alu(5'd7, 5'd1, 5'd0, 1'b0);
        nop(1'b0);
        chk("zero_reg_fwd_b", {30'b0, fwd_b}, 32'd0);

        // MEM beats WB when both wrote $3.
        alu(5'd3, 5'd1, 5'd2, 1'b0);
        alu(5'd3, 5'd1, 5'd2, 1'b0);
        alu(5'd8, 5'd3, 5'd1, 1'b0);
        nop(1'b0);
        chk("mem_priority", {30'b0, fwd_a}, 32'd2);

        // Load-use: lw $5 ; add rs=$5 (held in ID for one extra cycle)
        lw(5'd5, 5'd1);
        alu(5'd6, 5'd5, 5'd2, 1'b0);
        chk("lu_stall_f", {31'b0, stall_f}, 32'd1);
        chk("lu_stall_d", {31'b0, stall_d}, 32'd1);
        alu(5'd6, 5'd5, 5'd2, 1'b0);
        chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
        chk("lu_one_cycle", {31'b0, stall_d}, 32'd0);
        nop(1'b0);
        chk("lu_fwd_a", {30'b0, fwd_a}, 32'd1);

        // Branch taken in the same cycle as a load-use stall.
        lw(5'd5, 5'd1);
        alu(5'd6, 5'd5, 5'd2, 1'b1);
        chk("br_flush_d", {31'b0, flush_d}, 32'd1);
        chk("br_flush_e", {31'b0, flush_e}, 32'd1);
        chk("br_stall_d", {31'b0, stall_d}, 32'd0);
        nop(1'b0);
        chk("br_ex_bubble", {31'b0, ex_valid}, 32'd0);
        nop(1'b0);
        chk("br_mem_bubble", {31'b0, mem_valid}, 32'd0);

        // Reset pulsed in the middle of a stall.
        lw(5'd5, 5'd1);
        alu(5'd6, 5'd5, 5'd2, 1'b0);
        chk("pre_rst_stall", {31'b0, stall_d}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_kills_stall", {31'b0, stall_d}, 32'd0);
        chk("rst_kills_stall_f", {31'b0, stall_f}, 32'd0);
        chk("rst_ex_clear", {31'b0, ex_valid}, 32'd0);
        step(1'b1, 1'b1, 5'd6, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_held_stall", {31'b0, stall_d}, 32'd0);

        // Ten hazard-free instructions after release.
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 5'(i), '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("post_rst_nostall", {31'b0, stall_d}, 32'd0);
        end
        for (int i = 0; i < 4; i++) nop(1'b0);
`ifdef HAZARD_CTRL_PERF_EN
        chk("retired_10", 32'(perf_retired), 32'd10);
`else
        chk("retired_10", 32'(perf_retired), 32'd0);
`endif
        chk("stalls_0", 32'(perf_stalls), 32'd0);
        chk("flushes_0", 32'(perf_flushes), 32'd0);

        // Twenty more retirements push the 4-bit counter past its top.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 5'(i % 31 + 1), '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) nop(1'b0);
`ifdef HAZARD_CTRL_PERF_EN
        chk("retired_sat", 32'(perf_retired), 32'd15);
`else
        chk("retired_sat", 32'(perf_retired), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register address width.
REQ-002 Parameter CNT_W, default 32: performance counter width.
REQ-003 Parameter ZERO_REG_EN, default 1: when 1, address 0 never matches for forwarding or stall.
REQ-004 clk  in  1  clock; all state SHALL update on the falling edge, matching the pipeline registers.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 id_valid  in  1  ID holds a real instruction.
REQ-007 id_rs_addr, id_rt_addr  in  REG_ADDR_W each  ID source addresses.
REQ-008 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-009 id_dst_addr  in  REG_ADDR_W  ID destination after reg_dst mux.
REQ-010 id_reg_write, id_mem_to_reg  in  1 each  ID control bits.
REQ-011 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-012 stall_f, stall_d  out  1 each  hold PC and the IF/ID register.
REQ-013 flush_d, flush_e  out  1 each  invalidate the IF/ID and ID/EX registers at the next edge.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 WB result, 10 MEM ALU out.
REQ-015 ex_valid, mem_valid, wb_valid  out  1 each  per-stage valid bits.
REQ-016 perf_retired, perf_stalls, perf_flushes  out  CNT_W each  performance counters.

Function
REQ-017 The block SHALL keep shadow registers for E, M and W: valid, dst, reg_write and mem_to_reg. E SHALL also hold rs_addr and rt_addr.
REQ-018 Each edge: W<=M, M<=E, E<=ID fields with E.valid = id_valid & ~stall & ~flush_e.
REQ-019 Load-use stall (combinational) SHALL assert when all hold:
- E.valid & E.reg_write & E.mem_to_reg
- E.dst matches id_rs_addr with id_uses_rs, or id_rt_addr with id_uses_rt
- id_valid
- E.dst nonzero if ZERO_REG_EN
REQ-020 During a stall, stall_f = stall_d = 1 and exactly one bubble SHALL enter E; the stall lasts one cycle per load.
REQ-021 When ex_branch_taken = 1, flush_d = flush_e = 1 and stall_f = stall_d = 0; a branch SHALL override a stall in the same cycle.
REQ-022 fwd_a SHALL be:
- 10 if M.valid & M.reg_write & M.dst == E.rs_addr (nonzero when ZERO_REG_EN)
- else 01 if the same condition holds for W
- else 00
fwd_b SHALL use the same rule with E.rt_addr.
REQ-023 MEM SHALL take priority over WB when both match.
REQ-024 Forward selects SHALL be 00 whenever ex_valid = 0.
REQ-025 Invalid stages SHALL never cause a stall or a forward.

Reset
REQ-026 While rst = 1, all valid bits, shadow registers and counters SHALL be 0, all outputs SHALL be 0, and fwd_a = fwd_b = 00.
REQ-027 Reset asserted mid-stall or mid-flush SHALL clear it immediately, with no residual stall after release.
REQ-028 After release, the first id_valid SHALL reach wb_valid three falling edges later.

Configuration
REQ-029 With HAZARD_CTRL_PERF_EN defined, the counters SHALL count on each falling edge:
- perf_retired +1 when wb_valid
- perf_stalls +1 when stall_d
- perf_flushes +1 when ex_branch_taken
REQ-030 With HAZARD_CTRL_PERF_EN defined, each counter SHALL saturate at all-ones.
REQ-031 Without HAZARD_CTRL_PERF_EN, no counter registers SHALL exist and the perf_* outputs SHALL be constant 0.

Verification
REQ-032 ALU to ALU: add $3 followed by sub using rs = $3 -> fwd_a = 10 in the sub's EX cycle; no stall.
REQ-033 Two-apart dependency: add $3, nop, then or with rt = $3 -> fwd_b = 01. Same case with $0 and ZERO_REG_EN = 1 -> fwd_b = 00.
REQ-034 Load-use: lw $5 followed by add using rs = $5 -> stall_f = stall_d = 1 for exactly 1 cycle, ex_valid = 0 next cycle, then fwd_a = 01.
REQ-035 Branch taken together with a load-use stall in the same cycle -> flush_d = flush_e = 1, stall_d = 0, ex_valid = 0 and mem_valid = 0 at the following two edges.
REQ-036 rst pulsed during a stall, then 10 valid instructions with no hazards -> outputs 0 during reset; with PERF_EN, perf_retired = 10 and perf_stalls = 0.
REQ-037 Saturation: CNT_W = 4 with 20 retired instructions -> perf_retired holds at 15.
